// File: rtl/switch_debouncer_pkg.sv
// Shared constants and types for the switch debouncer.
// The default widths and debounce interval live here so every instantiation
// of the debouncer starts from the same board-level numbers.
package switch_debouncer_pkg;

  // Number of board switches conditioned by default.
  localparam int unsigned SWITCH_COUNT_DEF    = 8;
  // Consecutive stable cycles before a new level is accepted (250000 = 5 ms at 50 MHz).
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  // Per-bit counter width; must cover DEBOUNCE_CYCLES_DEF.
  localparam int unsigned CNT_WIDTH_DEF       = 20;

  // What a single bit does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,  // synchronized input agrees with accepted level
    ACT_COUNT  = 2'd1,  // input differs, still counting stable cycles
    ACT_ACCEPT = 2'd2   // input differed long enough, take it
  } bit_act_e;

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch channel: two-flop synchronizer, saturating stability counter,
// accepted level and registered rise/fall pulses. change_o is the
// combinational "accepting on this edge" indication, registered by the top.
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic change_o,
  output logic [1:0] act_o
);

  // Last count value before acceptance; the counter never goes past it.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q,  rise_d;
  logic                 fall_q,  fall_d;
  bit_act_e             act;

  // Decide the per-bit action and compute all next-state values.
  always_comb begin
    act     = ACT_HOLD;
    sync1_d = raw_i;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) act = ACT_ACCEPT;
      else                   act = ACT_COUNT;
    end

    unique case (act)
      ACT_COUNT: begin
        cnt_d = cnt_q + 1'b1;
      end
      ACT_ACCEPT: begin
        level_d = sync2_q;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // State register; reset clears synchronizer, count, level and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o  = level_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = (act == ACT_ACCEPT);
  assign act_o    = act;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces SWITCH_COUNT board switches independently and produces
// registered per-bit edge pulses plus a single "anything changed" pulse
// aligned with them.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int unsigned SWITCH_COUNT    = SWITCH_COUNT_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic                    boardCLK,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switchesRaw,
  output logic [SWITCH_COUNT-1:0] switches,
  output logic [SWITCH_COUNT-1:0] switchRise,
  output logic [SWITCH_COUNT-1:0] switchFall,
  output logic                    switchesChanged
);

  logic [SWITCH_COUNT-1:0] level_w;
  logic [SWITCH_COUNT-1:0] rise_w;
  logic [SWITCH_COUNT-1:0] fall_w;
  logic [SWITCH_COUNT-1:0] change_w;
  logic [1:0]              act_w [SWITCH_COUNT];
  logic                    chg_q, chg_d;

  for (genvar i = 0; i < SWITCH_COUNT; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_bit (
      .clk      (boardCLK),
      .rst      (reset),
      .raw_i    (switchesRaw[i]),
      .level_o  (level_w[i]),
      .rise_o   (rise_w[i]),
      .fall_o   (fall_w[i]),
      .change_o (change_w[i]),
      .act_o    (act_w[i])
    );
  end

  // Any bit accepting on this edge yields one aggregate pulse next cycle.
  always_comb begin
    chg_d = 1'b0;
    chg_d = |change_w;
  end

  // Aggregate change pulse register, aligned with per-bit rise/fall.
  always_ff @(posedge boardCLK) begin
    if (reset) chg_q <= 1'b0;
    else       chg_q <= chg_d;
  end

  assign switches        = level_w;
  assign switchRise      = rise_w;
  assign switchFall      = fall_w;
  assign switchesChanged = chg_q;

endmodule
